// File: rtl/cpu_ctrl_pkg.sv
// Shared control types for the CPU sequencer, bus multiplexer and datapath.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    S_START = 4'd0,
    S_F1    = 4'd1,
    S_F2    = 4'd2,
    S_F3    = 4'd3,
    S_DEC   = 4'd4,
    S_RD    = 4'd5,
    S_EXAC  = 4'd6,
    S_ST1   = 4'd7,
    S_ST2   = 4'd8,
    S_JMP   = 4'd9,
    S_HALT  = 4'd10
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_LDAC = 4'd1,
    OP_STAC = 4'd2,
    OP_JUMP = 4'd3,
    OP_JMPZ = 4'd4,
    OP_ADD  = 4'd5,
    OP_SUB  = 4'd6,
    OP_AND  = 4'd7,
    OP_OR   = 4'd8,
    OP_NOT  = 4'd9,
    OP_INAC = 4'd10,
    OP_CLAC = 4'd11,
    OP_HALT = 4'd15
  } opcode_t;

  typedef enum logic [2:0] {
    ALU_PASS = 3'd0,
    ALU_ADD  = 3'd1,
    ALU_SUB  = 3'd2,
    ALU_AND  = 3'd3,
    ALU_OR   = 3'd4,
    ALU_NOT  = 3'd5,
    ALU_INC  = 3'd6,
    ALU_CLR  = 3'd7
  } alu_op_t;

  localparam logic [1:0] BUS_PC  = 2'd0;
  localparam logic [1:0] BUS_DR  = 2'd1;
  localparam logic [1:0] BUS_MEM = 2'd2;

  typedef struct packed {
    logic [1:0] bus_sel;
    logic       ar_ld;
    logic       pc_ld;
    logic       pc_inc;
    logic       dr_ld;
    logic       dr_ld_ac;
    logic       ir_ld;
    logic       ac_ld;
    alu_op_t    alu_op;
    logic       mem_rd;
    logic       mem_wr;
    logic       halted;
    logic       illegal;
  } ctrl_t;

  function automatic logic is_reserved_op(input logic [3:0] op);
    return (op >= 4'd12) && (op <= 4'd14);
  endfunction

endpackage

// File: rtl/cpu_ctrl_decode.sv
// Combinational state+opcode -> control word decoder.
// CPU_CTRL_ILLEGAL_EN: reserved opcodes 12-14 raise illegal during DEC.
module cpu_ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  state_t      state_i,
  input  logic [3:0]  opcode_i,
  input  logic        mem_ready_i,
  output ctrl_t       ctrl_o
);

  always_comb begin
    ctrl_o         = '0;
    ctrl_o.bus_sel = BUS_PC;
    ctrl_o.alu_op  = ALU_PASS;
    case (state_i)
      S_F1: ctrl_o.ar_ld = 1'b1;
      S_F2: begin
        ctrl_o.bus_sel = BUS_MEM;
        ctrl_o.mem_rd  = 1'b1;
        ctrl_o.dr_ld   = 1'b1;
        // PC advances only once, in the cycle the fetch completes
        ctrl_o.pc_inc  = mem_ready_i;
      end
      S_F3: begin
        ctrl_o.bus_sel = BUS_DR;
        ctrl_o.ir_ld   = 1'b1;
        ctrl_o.ar_ld   = 1'b1;
      end
      S_DEC: begin
`ifdef CPU_CTRL_ILLEGAL_EN
        ctrl_o.illegal = is_reserved_op(opcode_i);
`endif
      end
      S_RD: begin
        ctrl_o.bus_sel = BUS_MEM;
        ctrl_o.mem_rd  = 1'b1;
        ctrl_o.dr_ld   = 1'b1;
      end
      S_EXAC: begin
        ctrl_o.bus_sel = BUS_DR;
        ctrl_o.ac_ld   = 1'b1;
        case (opcode_i)
          OP_ADD:  ctrl_o.alu_op = ALU_ADD;
          OP_SUB:  ctrl_o.alu_op = ALU_SUB;
          OP_AND:  ctrl_o.alu_op = ALU_AND;
          OP_OR:   ctrl_o.alu_op = ALU_OR;
          OP_NOT:  ctrl_o.alu_op = ALU_NOT;
          OP_INAC: ctrl_o.alu_op = ALU_INC;
          OP_CLAC: ctrl_o.alu_op = ALU_CLR;
          default: ctrl_o.alu_op = ALU_PASS;
        endcase
      end
      S_ST1: ctrl_o.dr_ld_ac = 1'b1;
      S_ST2: begin
        ctrl_o.bus_sel = BUS_DR;
        ctrl_o.mem_wr  = 1'b1;
      end
      S_JMP: begin
        ctrl_o.bus_sel = BUS_DR;
        ctrl_o.pc_ld   = 1'b1;
      end
      S_HALT: ctrl_o.halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_control_fsm.sv
// Fetch/decode/execute sequencer: state register and next-state logic.
// CPU_CTRL_ILLEGAL_EN: reserved opcodes 12-14 halt the CPU instead of acting as NOP.
module cpu_control_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int OPW  = 4,
  parameter int ALUW = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OPW-1:0]  ir_opcode,
  input  logic            z_flag,
  input  logic            mem_ready,
  output logic [1:0]      bus_sel,
  output logic            ar_ld,
  output logic            pc_ld,
  output logic            pc_inc,
  output logic            dr_ld,
  output logic            dr_ld_ac,
  output logic            ir_ld,
  output logic            ac_ld,
  output logic [ALUW-1:0] alu_op,
  output logic            mem_rd,
  output logic            mem_wr,
  output logic            halted,
  output logic            illegal
);

  state_t     state_q, state_d;
  logic [3:0] op;
  ctrl_t      ctrl;

  assign op = ir_opcode[3:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_START;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_START: state_d = S_F1;
      S_F1:    state_d = S_F2;
      S_F2:    if (mem_ready) state_d = S_F3;
      S_F3:    state_d = S_DEC;
      S_DEC: begin
        case (op)
          OP_NOP:                                state_d = S_F1;
          OP_LDAC, OP_ADD, OP_SUB, OP_AND, OP_OR: state_d = S_RD;
          OP_STAC:                               state_d = S_ST1;
          OP_JUMP:                               state_d = S_JMP;
          OP_JMPZ:                               state_d = z_flag ? S_JMP : S_F1;
          OP_NOT, OP_INAC, OP_CLAC:              state_d = S_EXAC;
          OP_HALT:                               state_d = S_HALT;
          default: begin
`ifdef CPU_CTRL_ILLEGAL_EN
            state_d = S_HALT;
`else
            state_d = S_F1;
`endif
          end
        endcase
      end
      S_RD:    if (mem_ready) state_d = S_EXAC;
      S_EXAC:  state_d = S_F1;
      S_ST1:   state_d = S_ST2;
      S_ST2:   if (mem_ready) state_d = S_F1;
      S_JMP:   state_d = S_F1;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_START;
    endcase
  end

  cpu_ctrl_decode u_decode (
    .state_i     (state_q),
    .opcode_i    (op),
    .mem_ready_i (mem_ready),
    .ctrl_o      (ctrl)
  );

  assign bus_sel  = ctrl.bus_sel;
  assign ar_ld    = ctrl.ar_ld;
  assign pc_ld    = ctrl.pc_ld;
  assign pc_inc   = ctrl.pc_inc;
  assign dr_ld    = ctrl.dr_ld;
  assign dr_ld_ac = ctrl.dr_ld_ac;
  assign ir_ld    = ctrl.ir_ld;
  assign ac_ld    = ctrl.ac_ld;
  assign alu_op   = ALUW'(ctrl.alu_op);
  assign mem_rd   = ctrl.mem_rd;
  assign mem_wr   = ctrl.mem_wr;
  assign halted   = ctrl.halted;
  assign illegal  = ctrl.illegal;

endmodule
